axi_lite_ram_ctrl: RTL and testbench
====================================

# axi_lite_ram_ctrl

AXI4-Lite slave controller that sequences the byte-lane data RAM (combinational read, clocked write). It buffers independent AW/W/AR requests, arbitrates reads against writes round-robin, and drives the RAM's ce/write_en/addr/sel/data_i pins. It registers RAM read data into R-channel responses. It sits between the SoC AXI-Lite interconnect and the data RAM.

## Interface
- `ADDR_WIDTH`, 32, AXI address width.
- `WORD_ADDR_WIDTH`, 17, RAM word-index width. Depth = 2^WORD_ADDR_WIDTH words; valid byte range is 0 .. 4*depth-1.
- `clk` in 1: single clock; everything is rising-edge.
- `resetn` in 1: asynchronous, active-low reset.
- `awvalid` in 1 / `awready` out 1 / `awaddr` in ADDR_WIDTH: write address channel.
- `wvalid` in 1 / `wready` out 1 / `wdata` in 32 / `wstrb` in 4: write data channel.
- `bvalid` out 1 / `bready` in 1 / `bresp` out 2: write response channel.
- `arvalid` in 1 / `arready` out 1 / `araddr` in ADDR_WIDTH: read address channel.
- `rvalid` out 1 / `rready` in 1 / `rdata` out 32 / `rresp` out 2: read data channel.
- `ram_ce` out 1, `ram_we` out 1, `ram_addr` out 32, `ram_sel` out 4, `ram_wdata` out 32: RAM drive.
- `ram_rdata` in 32: combinational RAM read data.

## Operation
- Three one-entry holding slots: AW (addr), W (data+strb), AR (addr).
  - Each slot's ready = slot empty. A slot fills on valid&&ready and is independent of FSM state.
- FSM states: IDLE, WRITE, READ, WRESP, RRESP.
- IDLE candidates:
  - A write is pending when AW and W are both full.
  - A read is pending when AR is full.
  - If only one is pending, take it.
  - If both are pending, take the opposite of the `last_wr` flag; `last_wr` resets to 1, so the first contention goes to the read.
  - `last_wr` updates on every grant.
- WRITE (1 cycle):
  - In range: ram_ce=1, ram_we=1, ram_addr={awaddr[31:2],2'b00}, ram_sel=wstrb, ram_wdata=wdata.
  - Free AW and W slots, latch bresp, go to WRESP.
- READ (1 cycle):
  - In range: ram_ce=1, ram_we=0, ram_addr=word-aligned araddr.
  - Capture ram_rdata into rdata at the cycle end, free AR, latch rresp, go to RRESP.
- WRESP: bvalid=1 until bready, then IDLE. RRESP: rvalid=1 until rready, then IDLE.
- Out-of-range address (byte addr ≥ 4*depth):
  - ram_ce stays 0 and the RAM is untouched.
  - Response is SLVERR (2'b10). For reads, rdata=0.
- In-range response is OKAY (2'b00).
- addr[1:0] is ignored (no misalignment error). wstrb=0 is a legal write with no byte change and OKAY response.
- Outside WRITE/READ, all ram_* outputs are 0.

## Timing
- Reset: state=IDLE, all slots empty, last_wr=1.
  - Outputs: awready=wready=arready=1, bvalid=rvalid=0, bresp=rresp=0, rdata=0, all ram_* = 0.
- Reset asserted mid-transaction aborts it. A write in WRITE during reset assertion is not guaranteed to commit.
- Latency, both paths complete (cycle 0 = handshake edge; for writes, the later of AW/W):
  - Cycle 1: WRITE/READ.
  - Cycle 2: bvalid/rvalid asserted.
  - Minimum 3 cycles per transaction including the response handshake.
- AW and W in different cycles: the write is eligible the cycle after the second one fills.
- Slots may refill while the FSM is in WRESP/RRESP, so back-to-back requests need no bubble on the request side.
- bvalid/rvalid, bresp/rresp and rdata stay stable while stalled on ready low.
- One outstanding transaction in the FSM at a time; responses are in grant order.

## Structure
- Shared header `define/axi.vh`:
  - RESP_OKAY, RESP_SLVERR.
  - FSM state encodings (3-bit).
- Reuse existing `DATA_BUS`, `ZEROWORD`, `CHIP_ENABLE`/`CHIP_DISABLE`, `WRITE_ENABLE`/`WRITE_DISABLE` macros for RAM-side values.
- One natural sub-module: `axi_hold_slot`, a parameterised-width valid/ready one-entry buffer with an external `pop`. Instantiate it three times (AW 32b, W 36b, AR 32b).

## Test plan
- Single write then read: AW=0x10, W=0xDEADBEEF, wstrb=4'hF; then AR=0x10 → bvalid at cycle 2 with bresp=00; rdata=0xDEADBEEF, rresp=00.
- Byte strobe: word at 0x20 holds 0x11223344, write 0xAABBCCDD with wstrb=4'b0101 → read returns 0x11BB33DD.
- Decoupled AW/W: W presented 3 cycles before AW=0x30 → ram_we pulses exactly once, the cycle after AW accepted; bvalid one cycle later.
- Contention: write and read both pending in IDLE out of reset → read granted first, write next; a repeat of the same contention → read again, because last_wr now 1.
- Out of range: AR=4*depth → rresp=10, rdata=0, ram_ce never asserted; an out-of-range write gives bresp=10 and RAM contents unchanged.
- Backpressure and reset: hold rready=0 for 5 cycles → rvalid/rdata stable; assert resetn=0 during RRESP → rvalid drops immediately and all readies return to 1.

Source files
------------

// File: rtl/axi_lite_ram_ctrl_pkg.sv
// Shared constants and types for the AXI4-Lite data-RAM controller:
// response codes, FSM encodings and RAM-side drive values.
package axi_lite_ram_ctrl_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_WRESP = 3'd3;
    localparam logic [2:0] ST_RRESP = 3'd4;

    localparam int          DATA_BUS      = 32;
    localparam logic [31:0] ZEROWORD      = 32'h0000_0000;
    localparam logic        CHIP_ENABLE   = 1'b1;
    localparam logic        CHIP_DISABLE  = 1'b0;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;

    // One buffered W beat: byte strobes on top, data underneath (36 bits).
    typedef struct packed {
        logic [3:0]          strb;
        logic [DATA_BUS-1:0] data;
    } wbeat_t;

    function automatic logic [1:0] resp_for(input logic in_range);
        return in_range ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axi_hold_slot.sv
// One-entry valid/ready holding buffer. Accepts whenever empty and is
// emptied only by an explicit pop from the consumer.
module axi_hold_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    // Pop is only issued while full, and ready is low while full, so a
    // fill and a pop can never land on the same edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end else if (i_valid && !r_full) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end
    end

    assign o_ready = !r_full;
    assign o_full  = r_full;
    assign o_data  = r_data;

endmodule

// File: rtl/axi_lite_ram_ctrl.sv
// AXI4-Lite slave in front of the byte-lane data RAM: buffers AW/W/AR,
// arbitrates reads against writes round-robin and registers read responses.
module axi_lite_ram_ctrl
    import axi_lite_ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int WORD_ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_BUS-1:0]   wdata,
    input  logic [3:0]            wstrb,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [1:0]            bresp,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DATA_BUS-1:0]   rdata,
    output logic [1:0]            rresp,
    output logic                  ram_ce,
    output logic                  ram_we,
    output logic [31:0]           ram_addr,
    output logic [3:0]            ram_sel,
    output logic [DATA_BUS-1:0]   ram_wdata,
    input  logic [DATA_BUS-1:0]   ram_rdata
);

    logic [2:0]          r_state;
    logic                r_last_wr;
    logic [1:0]          r_bresp;
    logic [1:0]          r_rresp;
    logic [DATA_BUS-1:0] r_rdata;

    logic                  w_aw_full;
    logic                  w_w_full;
    logic                  w_ar_full;
    logic [ADDR_WIDTH-1:0] w_aw_addr;
    logic [ADDR_WIDTH-1:0] w_ar_addr;
    wbeat_t                w_w_in;
    wbeat_t                w_w_out;
    logic                  w_pop_write;
    logic                  w_pop_read;
    logic                  w_wr_pend;
    logic                  w_rd_pend;
    logic                  w_aw_in_range;
    logic                  w_ar_in_range;
    logic [ADDR_WIDTH-1:0] w_aw_aligned;
    logic [ADDR_WIDTH-1:0] w_ar_aligned;

    assign w_w_in      = '{strb: wstrb, data: wdata};
    assign w_pop_write = (r_state == ST_WRITE);
    assign w_pop_read  = (r_state == ST_READ);

    axi_hold_slot #(.WIDTH(ADDR_WIDTH)) u_aw_slot (
        .clk     (clk),
        .resetn  (resetn),
        .i_valid (awvalid),
        .o_ready (awready),
        .i_data  (awaddr),
        .i_pop   (w_pop_write),
        .o_full  (w_aw_full),
        .o_data  (w_aw_addr)
    );

    axi_hold_slot #(.WIDTH($bits(wbeat_t))) u_w_slot (
        .clk     (clk),
        .resetn  (resetn),
        .i_valid (wvalid),
        .o_ready (wready),
        .i_data  (w_w_in),
        .i_pop   (w_pop_write),
        .o_full  (w_w_full),
        .o_data  (w_w_out)
    );

    axi_hold_slot #(.WIDTH(ADDR_WIDTH)) u_ar_slot (
        .clk     (clk),
        .resetn  (resetn),
        .i_valid (arvalid),
        .o_ready (arready),
        .i_data  (araddr),
        .i_pop   (w_pop_read),
        .o_full  (w_ar_full),
        .o_data  (w_ar_addr)
    );

    assign w_wr_pend = w_aw_full && w_w_full;
    assign w_rd_pend = w_ar_full;

    // Any address bit at or above the top of RAM makes the access out of range.
    assign w_aw_in_range = ((w_aw_addr >> (WORD_ADDR_WIDTH + 2)) == '0);
    assign w_ar_in_range = ((w_ar_addr >> (WORD_ADDR_WIDTH + 2)) == '0);
    assign w_aw_aligned  = {w_aw_addr[ADDR_WIDTH-1:2], 2'b00};
    assign w_ar_aligned  = {w_ar_addr[ADDR_WIDTH-1:2], 2'b00};

    // Under contention the grant goes opposite to the previous grant; the
    // flag starts at "write" so the first tie is resolved in favour of a read.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_last_wr <= 1'b1;
            r_bresp   <= RESP_OKAY;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= ZEROWORD;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_pend && (!w_rd_pend || !r_last_wr)) begin
                        r_state   <= ST_WRITE;
                        r_last_wr <= 1'b1;
                    end else if (w_rd_pend) begin
                        r_state   <= ST_READ;
                        r_last_wr <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    r_bresp <= resp_for(w_aw_in_range);
                    r_state <= ST_WRESP;
                end
                ST_READ: begin
                    r_rresp <= resp_for(w_ar_in_range);
                    r_rdata <= w_ar_in_range ? ram_rdata : ZEROWORD;
                    r_state <= ST_RRESP;
                end
                ST_WRESP: begin
                    if (bready) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RRESP: begin
                    if (rready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The RAM sees activity only during the single WRITE/READ cycle and
    // only for in-range addresses; otherwise every pin is parked at zero.
    always_comb begin
        ram_ce    = CHIP_DISABLE;
        ram_we    = WRITE_DISABLE;
        ram_addr  = 32'h0;
        ram_sel   = 4'h0;
        ram_wdata = ZEROWORD;
        if (r_state == ST_WRITE && w_aw_in_range) begin
            ram_ce    = CHIP_ENABLE;
            ram_we    = WRITE_ENABLE;
            ram_addr  = 32'(w_aw_aligned);
            ram_sel   = w_w_out.strb;
            ram_wdata = w_w_out.data;
        end else if (r_state == ST_READ && w_ar_in_range) begin
            ram_ce    = CHIP_ENABLE;
            ram_addr  = 32'(w_ar_aligned);
        end
    end

    assign bvalid = (r_state == ST_WRESP);
    assign bresp  = r_bresp;
    assign rvalid = (r_state == ST_RRESP);
    assign rresp  = r_rresp;
    assign rdata  = r_rdata;

endmodule

// File: tb/tb_axi_lite_ram_ctrl.sv
// Directed self-checking bench for axi_lite_ram_ctrl with a byte-lane RAM
// model, a shadow memory and an in-order response scoreboard.
module tb_axi_lite_ram_ctrl;

    localparam int          WAW      = 17;
    localparam logic [31:0] OOR_BASE = 32'h0008_0000;

    typedef struct {
        bit          isRead;
        logic [1:0]  resp;
        logic [31:0] data;
        string       tag;
    } expResp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        ram_ce, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_sel;

    expResp_t    scoreboard[$];
    logic [31:0] expMem[int];
    logic [31:0] ramModel[0:(1<<WAW)-1];
    bit          lastWrModel = 1'b1;
    int          nAsserts = 0;
    int          nFails = 0;
    int          ceCount = 0;
    int          weCount = 0;

    axi_lite_ram_ctrl #(.ADDR_WIDTH(32), .WORD_ADDR_WIDTH(WAW)) dut (
        .clk(clk), .resetn(resetn),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_sel(ram_sel), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Data RAM: combinational read, byte-lane clocked write.
    assign ram_rdata = ramModel[ram_addr[WAW+1:2]];

    always @(posedge clk) begin
        if (ram_ce) ceCount <= ceCount + 1;
        if (ram_ce && ram_we) begin
            weCount <= weCount + 1;
            for (int b = 0; b < 4; b++)
                if (ram_sel[b]) ramModel[ram_addr[WAW+1:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    function automatic logic [31:0] expRead(input logic [31:0] addr);
        int idx = int'(addr[WAW+1:2]);
        return expMem.exists(idx) ? expMem[idx] : 32'h0;
    endfunction

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldW, input logic [31:0] newW,
                                               input logic [3:0] strb);
        logic [31:0] r = oldW;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = newW[8*b +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checkOutput(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    task automatic checkBound(input string tag, input bit expired);
        nAsserts++;
        assert (!expired) else begin
            nFails++;
            $display("[TB] FAIL %s observed=timeout expected=event within bound", tag);
        end
    endtask

    task automatic pushWrite(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input string tag);
        expResp_t e;
        bit inRange = (addr < OOR_BASE);
        if (inRange) expMem[int'(addr[WAW+1:2])] = mergeBytes(expRead(addr), data, strb);
        e.isRead = 1'b0;
        e.resp   = inRange ? 2'b00 : 2'b10;
        e.data   = 32'h0;
        e.tag    = tag;
        scoreboard.push_back(e);
        lastWrModel = 1'b1;
    endtask

    task automatic pushRead(input logic [31:0] addr, input string tag);
        expResp_t e;
        bit inRange = (addr < OOR_BASE);
        e.isRead = 1'b1;
        e.resp   = inRange ? 2'b00 : 2'b10;
        e.data   = inRange ? expRead(addr) : 32'h0;
        e.tag    = tag;
        scoreboard.push_back(e);
        lastWrModel = 1'b0;
    endtask

    // Presents a write, a read or both at once; returns just after the
    // edge on which the last of the requested channels handshook.
    task automatic applyStimulus(input bit doW, input bit doR, input logic [31:0] wAddr,
                                 input logic [31:0] wData, input logic [3:0] strb,
                                 input logic [31:0] rAddr, input string tag);
        bit readFirst;
        awaddr  = wAddr;
        wdata   = wData;
        wstrb   = strb;
        araddr  = rAddr;
        awvalid = doW;
        wvalid  = doW;
        arvalid = doR;
        for (int i = 0; i < 20 && (awvalid || wvalid || arvalid); i++) begin
            logic aAcc, wAcc, rAcc;
            aAcc = awvalid && awready;
            wAcc = wvalid && wready;
            rAcc = arvalid && arready;
            tick();
            if (aAcc) awvalid = 1'b0;
            if (wAcc) wvalid = 1'b0;
            if (rAcc) arvalid = 1'b0;
        end
        checkBound({tag, " request accept"}, awvalid || wvalid || arvalid);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
        readFirst = doR && (!doW || lastWrModel);
        if (readFirst) pushRead(rAddr, tag);
        if (doW) pushWrite(wAddr, wData, strb, tag);
        if (doR && !readFirst) pushRead(rAddr, tag);
    endtask

    task automatic collectResponse();
        expResp_t e;
        bit expired = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bvalid || rvalid) begin
                expired = 1'b0;
                break;
            end
            tick();
        end
        checkBound("response wait", expired);
        if (!expired) begin
            checkBound("scoreboard has entry", scoreboard.size() == 0);
            if (scoreboard.size() != 0) begin
                e = scoreboard.pop_front();
                checkBit({e.tag, " kind(rvalid)"}, rvalid, e.isRead);
                if (e.isRead) begin
                    checkOutput({e.tag, " rresp"}, {30'b0, rresp}, {30'b0, e.resp});
                    checkOutput({e.tag, " rdata"}, rdata, e.data);
                end else begin
                    checkOutput({e.tag, " bresp"}, {30'b0, bresp}, {30'b0, e.resp});
                end
            end
            tick();
        end
    endtask

    initial begin
        int snap;
        expResp_t held;
        for (int i = 0; i < (1 << WAW); i++) ramModel[i] = 32'h0;
        resetn  = 1'b1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        awaddr  = '0; araddr = '0; wdata = '0; wstrb = '0;
        bready  = 1'b1; rready = 1'b1;
        #2 resetn = 1'b0;
        tick();
        tick();
        $display("[TB] reset state");
        checkBit("reset awready", awready, 1'b1);
        checkBit("reset wready", wready, 1'b1);
        checkBit("reset arready", arready, 1'b1);
        checkBit("reset bvalid", bvalid, 1'b0);
        checkBit("reset rvalid", rvalid, 1'b0);
        checkOutput("reset bresp", {30'b0, bresp}, 32'h0);
        checkOutput("reset rresp", {30'b0, rresp}, 32'h0);
        checkOutput("reset rdata", rdata, 32'h0);
        checkBit("reset ram_ce", ram_ce, 1'b0);
        checkBit("reset ram_we", ram_we, 1'b0);
        checkOutput("reset ram_addr", ram_addr, 32'h0);
        checkOutput("reset ram_sel", {28'b0, ram_sel}, 32'h0);
        checkOutput("reset ram_wdata", ram_wdata, 32'h0);
        resetn = 1'b1;
        tick();

        $display("[TB] contention out of reset");
        applyStimulus(1, 1, 32'h40, 32'h1234_5678, 4'hF, 32'h40, "cont1");
        tick();
        checkBit("cont1 read granted ram_we", ram_we, 1'b0);
        checkBit("cont1 read granted ram_ce", ram_ce, 1'b1);
        collectResponse();
        collectResponse();
        applyStimulus(1, 1, 32'h40, 32'h9ABC_DEF0, 4'hF, 32'h40, "cont2");
        tick();
        checkBit("cont2 read granted ram_we", ram_we, 1'b0);
        collectResponse();
        collectResponse();

        $display("[TB] single write then read");
        applyStimulus(1, 0, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, "wr10");
        tick();
        checkBit("wr10 ram_ce", ram_ce, 1'b1);
        checkBit("wr10 ram_we", ram_we, 1'b1);
        checkOutput("wr10 ram_addr", ram_addr, 32'h10);
        checkOutput("wr10 ram_sel", {28'b0, ram_sel}, 32'hF);
        checkOutput("wr10 ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        tick();
        checkBit("wr10 bvalid cycle2", bvalid, 1'b1);
        collectResponse();
        applyStimulus(0, 1, 32'h0, 32'h0, 4'h0, 32'h13, "rd10");
        tick();
        checkBit("rd10 ram_ce", ram_ce, 1'b1);
        checkOutput("rd10 ram_addr aligned", ram_addr, 32'h10);
        tick();
        checkBit("rd10 rvalid cycle2", rvalid, 1'b1);
        collectResponse();

        $display("[TB] byte strobes");
        applyStimulus(1, 0, 32'h20, 32'h1122_3344, 4'hF, 32'h0, "wr20full");
        collectResponse();
        applyStimulus(1, 0, 32'h20, 32'hAABB_CCDD, 4'b0101, 32'h0, "wr20strb");
        collectResponse();
        applyStimulus(0, 1, 32'h0, 32'h0, 4'h0, 32'h20, "rd20");
        collectResponse();
        applyStimulus(1, 0, 32'h20, 32'hFFFF_FFFF, 4'b0000, 32'h0, "wr20none");
        collectResponse();

        $display("[TB] decoupled AW/W");
        snap   = weCount;
        wdata  = 32'h0BAD_CAFE;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        checkBit("decoupled no write W only", ram_we, 1'b0);
        tick();
        tick();
        checkBit("decoupled no write before AW", ram_we, 1'b0);
        awaddr  = 32'h30;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        pushWrite(32'h30, 32'h0BAD_CAFE, 4'hF, "wr30");
        checkBit("decoupled no write on AW edge", ram_we, 1'b0);
        tick();
        checkBit("decoupled ram_we cycle after AW", ram_we, 1'b1);
        checkOutput("decoupled ram_addr", ram_addr, 32'h30);
        tick();
        checkBit("decoupled bvalid", bvalid, 1'b1);
        collectResponse();
        checkOutput("decoupled single we pulse", weCount - snap, 32'd1);

        $display("[TB] out of range and top boundary");
        snap = ceCount;
        applyStimulus(0, 1, 32'h0, 32'h0, 4'h0, OOR_BASE, "oorRd");
        tick();
        checkBit("oorRd ram_ce", ram_ce, 1'b0);
        collectResponse();
        applyStimulus(1, 0, OOR_BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 32'h0, "oorWr");
        tick();
        checkBit("oorWr ram_ce", ram_ce, 1'b0);
        collectResponse();
        checkOutput("oor ram_ce never asserted", ceCount - snap, 32'd0);
        applyStimulus(0, 1, 32'h0, 32'h0, 4'h0, 32'h20, "rd20after");
        collectResponse();
        applyStimulus(1, 0, OOR_BASE - 32'h4, 32'h5A5A_A5A5, 4'hF, 32'h0, "wrTop");
        collectResponse();
        applyStimulus(0, 1, 32'h0, 32'h0, 4'h0, OOR_BASE - 32'h1, "rdTop");
        collectResponse();

        $display("[TB] backpressure and reset");
        applyStimulus(1, 0, 32'h50, 32'hCAFE_F00D, 4'hF, 32'h0, "wr50");
        collectResponse();
        rready = 1'b0;
        applyStimulus(0, 1, 32'h0, 32'h0, 4'h0, 32'h50, "rd50stall");
        held = scoreboard.pop_front();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            checkBit("stall rvalid", rvalid, 1'b1);
            checkOutput("stall rdata", rdata, held.data);
            checkOutput("stall rresp", {30'b0, rresp}, {30'b0, held.resp});
            tick();
        end
        resetn = 1'b0;
        #1;
        checkBit("midreset rvalid", rvalid, 1'b0);
        checkBit("midreset awready", awready, 1'b1);
        checkBit("midreset wready", wready, 1'b1);
        checkBit("midreset arready", arready, 1'b1);
        checkOutput("midreset rdata", rdata, 32'h0);
        scoreboard.delete();
        lastWrModel = 1'b1;
        tick();
        resetn = 1'b1;
        rready = 1'b1;
        tick();
        applyStimulus(0, 1, 32'h0, 32'h0, 4'h0, 32'h50, "rd50after");
        collectResponse();

        checkOutput("scoreboard drained", scoreboard.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
